// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port DMEM between the pipeline memory stage (core) and an
// external requester, with a starvation counter that forces one external grant.
module dmem_arbiter #(
  parameter int DMEM_ADDR_WIDTH = 12,
  parameter int DMEM_WORD_WIDTH = 16,
  parameter int STARVE_LIMIT    = 4,
  parameter int CNT_WIDTH       = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_core_load,
  input  logic                       in_core_store,
  input  logic [DMEM_ADDR_WIDTH-1:0] in_core_addr,
  input  logic [DMEM_WORD_WIDTH-1:0] in_core_wr_word,
  output logic                       out_core_stall,
  input  logic                       in_ext_req,
  input  logic                       in_ext_we,
  input  logic [DMEM_ADDR_WIDTH-1:0] in_ext_addr,
  input  logic [DMEM_WORD_WIDTH-1:0] in_ext_wr_word,
  output logic                       out_ext_ack,
  output logic                       out_ext_rd_valid,
  output logic [DMEM_WORD_WIDTH-1:0] out_ext_rd_word,
  input  logic [DMEM_WORD_WIDTH-1:0] in_mem_rd_word,
  output logic [DMEM_ADDR_WIDTH-1:0] out_mem_addr,
  output logic [DMEM_WORD_WIDTH-1:0] out_mem_wr_word,
  output logic                       out_mem_write_en,
  output logic                       out_dbg_state,
  output logic [CNT_WIDTH-1:0]       out_dbg_wait_cnt
);

  // Ext handshake: the requester holds in_ext_req/we/addr/wr_word stable until it
  // sees out_ext_ack high in a cycle; that cycle is the transfer. It may drop or
  // change the request in the following cycle.

  typedef enum logic {ST_CORE = 1'b0, ST_FORCE = 1'b1} state_t;

  localparam logic [CNT_WIDTH-1:0] LIMIT    = CNT_WIDTH'(STARVE_LIMIT);
  localparam logic [CNT_WIDTH-1:0] LIMIT_M1 = CNT_WIDTH'(STARVE_LIMIT - 1);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;
  logic                 rd_pending_q, rd_pending_d;
  logic                 core_req, core_grant, ext_grant;

  always_comb begin
    core_req   = in_core_load | in_core_store;
    core_grant = 1'b0;
    ext_grant  = 1'b0;
    case (state_q)
      ST_FORCE: begin
        ext_grant  = in_ext_req;
        core_grant = core_req && !in_ext_req;
      end
      default: begin
        core_grant = core_req;
        ext_grant  = !core_req && in_ext_req;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CORE:  if (in_ext_req && !ext_grant && wait_cnt_q == LIMIT_M1) state_d = ST_FORCE;
      ST_FORCE: if (ext_grant || !in_ext_req) state_d = ST_CORE;
      default:  state_d = ST_CORE;
    endcase

    // Counts losing cycles of a pending ext request, saturating at the limit.
    wait_cnt_d = wait_cnt_q;
    if (!in_ext_req || ext_grant) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != LIMIT) begin
      wait_cnt_d = wait_cnt_q + CNT_WIDTH'(1);
    end

    rd_pending_d = ext_grant && !in_ext_we;
  end

  always_comb begin
    out_mem_addr     = '0;
    out_mem_wr_word  = '0;
    out_mem_write_en = 1'b0;
    if (core_grant) begin
      out_mem_addr     = in_core_addr;
      out_mem_wr_word  = in_core_wr_word;
      out_mem_write_en = in_core_store;
    end else if (ext_grant) begin
      out_mem_addr     = in_ext_addr;
      out_mem_wr_word  = in_ext_wr_word;
      out_mem_write_en = in_ext_we;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_CORE;
      wait_cnt_q   <= '0;
      rd_pending_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      rd_pending_q <= rd_pending_d;
    end
  end

  assign out_core_stall   = core_req && !core_grant;
  assign out_ext_ack      = ext_grant;
  assign out_ext_rd_valid = rd_pending_q;
  assign out_ext_rd_word  = rd_pending_q ? in_mem_rd_word : '0;
  assign out_dbg_state    = state_q;
  assign out_dbg_wait_cnt = wait_cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one task per scenario, with a behavioural DMEM
// model driven by the arbiter's memory port.
module tb_dmem_arbiter;

  logic        clock, reset;
  logic        in_core_load, in_core_store;
  logic [11:0] in_core_addr;
  logic [15:0] in_core_wr_word;
  logic        out_core_stall;
  logic        in_ext_req, in_ext_we;
  logic [11:0] in_ext_addr;
  logic [15:0] in_ext_wr_word;
  logic        out_ext_ack, out_ext_rd_valid;
  logic [15:0] out_ext_rd_word;
  logic [15:0] in_mem_rd_word;
  logic [11:0] out_mem_addr;
  logic [15:0] out_mem_wr_word;
  logic        out_mem_write_en;
  logic        out_dbg_state;
  logic [3:0]  out_dbg_wait_cnt;

  int checks = 0;
  int failures = 0;

  logic [15:0] mem [0:4095];

  dmem_arbiter #(.DMEM_ADDR_WIDTH(12), .DMEM_WORD_WIDTH(16), .STARVE_LIMIT(4), .CNT_WIDTH(4)) dut (
    .clock(clock), .reset(reset),
    .in_core_load(in_core_load), .in_core_store(in_core_store),
    .in_core_addr(in_core_addr), .in_core_wr_word(in_core_wr_word),
    .out_core_stall(out_core_stall),
    .in_ext_req(in_ext_req), .in_ext_we(in_ext_we),
    .in_ext_addr(in_ext_addr), .in_ext_wr_word(in_ext_wr_word),
    .out_ext_ack(out_ext_ack), .out_ext_rd_valid(out_ext_rd_valid),
    .out_ext_rd_word(out_ext_rd_word),
    .in_mem_rd_word(in_mem_rd_word),
    .out_mem_addr(out_mem_addr), .out_mem_wr_word(out_mem_wr_word),
    .out_mem_write_en(out_mem_write_en),
    .out_dbg_state(out_dbg_state), .out_dbg_wait_cnt(out_dbg_wait_cnt)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // DMEM model: write commits at the edge, read data appears the cycle after the address
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    in_mem_rd_word = 16'h0000;
  end
  always @(posedge clock) begin
    if (out_mem_write_en) mem[out_mem_addr] <= out_mem_wr_word;
    in_mem_rd_word <= mem[out_mem_addr];
  end

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_core(input logic ld, input logic st, input logic [11:0] a, input logic [15:0] d);
    in_core_load = ld; in_core_store = st; in_core_addr = a; in_core_wr_word = d;
  endtask

  task automatic set_ext(input logic rq, input logic we, input logic [11:0] a, input logic [15:0] d);
    in_ext_req = rq; in_ext_we = we; in_ext_addr = a; in_ext_wr_word = d;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_core(0, 0, 12'h0, 16'h0);
    set_ext(0, 0, 12'h0, 16'h0);
    tick();
    #2;
    checks++; if (out_dbg_state !== 1'b0) begin failures++; $display("FAIL reset_state got=%0h exp=0", out_dbg_state); end
    checks++; if (out_dbg_wait_cnt !== 4'd0) begin failures++; $display("FAIL reset_wait_cnt got=%0h exp=0", out_dbg_wait_cnt); end
    checks++; if (out_ext_rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%0h exp=0", out_ext_rd_valid); end
    checks++; if (out_ext_rd_word !== 16'h0) begin failures++; $display("FAIL reset_rd_word got=%0h exp=0", out_ext_rd_word); end
    checks++; if (out_mem_write_en !== 1'b0 || out_mem_addr !== 12'h0) begin failures++; $display("FAIL reset_mem_idle got=%0h/%0h exp=0/0", out_mem_write_en, out_mem_addr); end
    // ext grant under reset only when the core is idle
    set_ext(1, 0, 12'h055, 16'h0);
    #1;
    checks++; if (out_ext_ack !== 1'b1) begin failures++; $display("FAIL reset_ext_ack_idle got=%0h exp=1", out_ext_ack); end
    set_core(1, 0, 12'h011, 16'h0);
    #1;
    checks++; if (out_ext_ack !== 1'b0 || out_core_stall !== 1'b0) begin failures++; $display("FAIL reset_core_wins got=%0h/%0h exp=0/0", out_ext_ack, out_core_stall); end
    set_core(0, 0, 12'h0, 16'h0);
    set_ext(0, 0, 12'h0, 16'h0);
    tick();
    reset = 1'b0;
  endtask

  task automatic test_core_only();
    set_core(0, 1, 12'h010, 16'hBEEF);
    #2;
    checks++; if (out_mem_write_en !== 1'b1 || out_mem_addr !== 12'h010 || out_mem_wr_word !== 16'hBEEF) begin failures++; $display("FAIL core_store_drive got=%0h/%0h/%0h exp=1/10/beef", out_mem_write_en, out_mem_addr, out_mem_wr_word); end
    checks++; if (out_core_stall !== 1'b0 || out_ext_ack !== 1'b0) begin failures++; $display("FAIL core_store_stall got=%0h/%0h exp=0/0", out_core_stall, out_ext_ack); end
    tick();
    set_core(1, 0, 12'h010, 16'h0);
    #2;
    checks++; if (out_mem_write_en !== 1'b0 || out_mem_addr !== 12'h010 || out_core_stall !== 1'b0) begin failures++; $display("FAIL core_load_drive got=%0h/%0h/%0h exp=0/10/0", out_mem_write_en, out_mem_addr, out_core_stall); end
    tick();
    set_core(0, 0, 12'h0, 16'h0);
    #2;
    checks++; if (in_mem_rd_word !== 16'hBEEF) begin failures++; $display("FAIL core_load_data got=%0h exp=beef", in_mem_rd_word); end
    checks++; if (out_ext_rd_valid !== 1'b0) begin failures++; $display("FAIL core_load_no_ext_valid got=%0h exp=0", out_ext_rd_valid); end
    tick();
  endtask

  task automatic test_ext_only();
    set_ext(1, 1, 12'h020, 16'h1234);
    #2;
    checks++; if (out_ext_ack !== 1'b1 || out_mem_write_en !== 1'b1 || out_mem_addr !== 12'h020 || out_mem_wr_word !== 16'h1234) begin failures++; $display("FAIL ext_write got=%0h/%0h/%0h/%0h exp=1/1/20/1234", out_ext_ack, out_mem_write_en, out_mem_addr, out_mem_wr_word); end
    tick();
    set_ext(1, 0, 12'h020, 16'h0);
    #2;
    checks++; if (out_ext_ack !== 1'b1 || out_mem_write_en !== 1'b0 || out_ext_rd_valid !== 1'b0) begin failures++; $display("FAIL ext_read_ack got=%0h/%0h/%0h exp=1/0/0", out_ext_ack, out_mem_write_en, out_ext_rd_valid); end
    checks++; if (out_dbg_wait_cnt !== 4'd0) begin failures++; $display("FAIL ext_only_wait got=%0h exp=0", out_dbg_wait_cnt); end
    tick();
    set_ext(0, 0, 12'h0, 16'h0);
    #2;
    checks++; if (out_ext_rd_valid !== 1'b1 || out_ext_rd_word !== 16'h1234) begin failures++; $display("FAIL ext_read_data got=%0h/%0h exp=1/1234", out_ext_rd_valid, out_ext_rd_word); end
    checks++; if (out_ext_ack !== 1'b0) begin failures++; $display("FAIL ext_idle_ack got=%0h exp=0", out_ext_ack); end
    tick();
    #2;
    checks++; if (out_ext_rd_valid !== 1'b0 || out_ext_rd_word !== 16'h0) begin failures++; $display("FAIL ext_valid_one_cycle got=%0h/%0h exp=0/0", out_ext_rd_valid, out_ext_rd_word); end
    tick();
  endtask

  task automatic test_contention();
    set_core(1, 0, 12'h010, 16'h0);
    set_ext(1, 0, 12'h020, 16'h0);
    for (int c = 0; c < 4; c++) begin
      #2;
      checks++; if (out_ext_ack !== 1'b0 || out_core_stall !== 1'b0 || out_mem_addr !== 12'h010) begin failures++; $display("FAIL cont_cycle%0d_grant got=%0h/%0h/%0h exp=0/0/10", c, out_ext_ack, out_core_stall, out_mem_addr); end
      checks++; if (out_dbg_wait_cnt !== 4'(c) || out_dbg_state !== 1'b0) begin failures++; $display("FAIL cont_cycle%0d_cnt got=%0h/%0h exp=%0h/0", c, out_dbg_wait_cnt, out_dbg_state, c); end
      tick();
    end
    #2;
    checks++; if (out_ext_ack !== 1'b1 || out_core_stall !== 1'b1 || out_mem_addr !== 12'h020) begin failures++; $display("FAIL cont_forced got=%0h/%0h/%0h exp=1/1/20", out_ext_ack, out_core_stall, out_mem_addr); end
    checks++; if (out_dbg_state !== 1'b1 || out_dbg_wait_cnt !== 4'd4) begin failures++; $display("FAIL cont_force_state got=%0h/%0h exp=1/4", out_dbg_state, out_dbg_wait_cnt); end
    tick();
    set_ext(0, 0, 12'h0, 16'h0);
    #2;
    checks++; if (out_ext_ack !== 1'b0 || out_core_stall !== 1'b0 || out_mem_addr !== 12'h010) begin failures++; $display("FAIL cont_core_back got=%0h/%0h/%0h exp=0/0/10", out_ext_ack, out_core_stall, out_mem_addr); end
    checks++; if (out_ext_rd_valid !== 1'b1 || out_ext_rd_word !== 16'h1234) begin failures++; $display("FAIL cont_rd_data got=%0h/%0h exp=1/1234", out_ext_rd_valid, out_ext_rd_word); end
    checks++; if (out_dbg_state !== 1'b0 || out_dbg_wait_cnt !== 4'd0) begin failures++; $display("FAIL cont_after_state got=%0h/%0h exp=0/0", out_dbg_state, out_dbg_wait_cnt); end
    set_core(0, 0, 12'h0, 16'h0);
    tick();
  endtask

  task automatic test_drop_on_force();
    set_core(1, 0, 12'h010, 16'h0);
    set_ext(1, 0, 12'h020, 16'h0);
    for (int c = 0; c < 4; c++) tick();
    set_ext(0, 0, 12'h0, 16'h0);
    #2;
    checks++; if (out_dbg_state !== 1'b1) begin failures++; $display("FAIL drop_in_force got=%0h exp=1", out_dbg_state); end
    checks++; if (out_ext_ack !== 1'b0 || out_core_stall !== 1'b0 || out_mem_addr !== 12'h010) begin failures++; $display("FAIL drop_grant got=%0h/%0h/%0h exp=0/0/10", out_ext_ack, out_core_stall, out_mem_addr); end
    tick();
    #2;
    checks++; if (out_dbg_state !== 1'b0 || out_dbg_wait_cnt !== 4'd0 || out_ext_rd_valid !== 1'b0) begin failures++; $display("FAIL drop_after got=%0h/%0h/%0h exp=0/0/0", out_dbg_state, out_dbg_wait_cnt, out_ext_rd_valid); end
    set_core(0, 0, 12'h0, 16'h0);
    tick();
  endtask

  task automatic test_reset_mid();
    set_ext(1, 0, 12'h020, 16'h0);
    #2;
    checks++; if (out_ext_ack !== 1'b1) begin failures++; $display("FAIL rstmid_ack got=%0h exp=1", out_ext_ack); end
    tick();
    set_ext(0, 0, 12'h0, 16'h0);
    reset = 1'b1;
    #1;
    checks++; if (out_ext_rd_valid !== 1'b0 || out_ext_rd_word !== 16'h0 || out_dbg_state !== 1'b0) begin failures++; $display("FAIL rstmid_drop got=%0h/%0h/%0h exp=0/0/0", out_ext_rd_valid, out_ext_rd_word, out_dbg_state); end
    tick();
    reset = 1'b0;
    #2;
    checks++; if (out_ext_rd_valid !== 1'b0) begin failures++; $display("FAIL rstmid_no_reissue got=%0h exp=0", out_ext_rd_valid); end
    // build up a wait count, then check the asynchronous clear
    set_core(1, 0, 12'h010, 16'h0);
    set_ext(1, 0, 12'h020, 16'h0);
    tick();
    tick();
    checks++; if (out_dbg_wait_cnt !== 4'd2) begin failures++; $display("FAIL rstmid_cnt_pre got=%0h exp=2", out_dbg_wait_cnt); end
    reset = 1'b1;
    #1;
    checks++; if (out_dbg_wait_cnt !== 4'd0 || out_dbg_state !== 1'b0) begin failures++; $display("FAIL rstmid_cnt_clear got=%0h/%0h exp=0/0", out_dbg_wait_cnt, out_dbg_state); end
    set_core(0, 0, 12'h0, 16'h0);
    set_ext(0, 0, 12'h0, 16'h0);
    tick();
    reset = 1'b0;
    set_core(0, 1, 12'h030, 16'hCAFE);
    set_ext(1, 0, 12'h020, 16'h0);
    #2;
    checks++; if (out_mem_write_en !== 1'b1 || out_mem_addr !== 12'h030 || out_ext_ack !== 1'b0) begin failures++; $display("FAIL rstmid_core_after got=%0h/%0h/%0h exp=1/30/0", out_mem_write_en, out_mem_addr, out_ext_ack); end
    checks++; if (out_dbg_wait_cnt !== 4'd0) begin failures++; $display("FAIL rstmid_cnt_fresh got=%0h exp=0", out_dbg_wait_cnt); end
    tick();
    set_core(0, 0, 12'h0, 16'h0);
    #2;
    checks++; if (out_ext_ack !== 1'b1 || out_dbg_wait_cnt !== 4'd1) begin failures++; $display("FAIL rstmid_ext_after got=%0h/%0h exp=1/1", out_ext_ack, out_dbg_wait_cnt); end
    tick();
    set_ext(0, 0, 12'h0, 16'h0);
    #2;
    checks++; if (out_ext_rd_valid !== 1'b1 || out_ext_rd_word !== 16'h1234) begin failures++; $display("FAIL rstmid_ext_data got=%0h/%0h exp=1/1234", out_ext_rd_valid, out_ext_rd_word); end
    tick();
  endtask

  task automatic test_back_to_back();
    set_core(0, 1, 12'h040, 16'hAAAA);
    set_ext(1, 1, 12'h040, 16'h5555);
    #2;
    checks++; if (out_ext_ack !== 1'b0 || out_core_stall !== 1'b0 || out_mem_write_en !== 1'b1 || out_mem_wr_word !== 16'hAAAA) begin failures++; $display("FAIL both_store_core got=%0h/%0h/%0h/%0h exp=0/0/1/aaaa", out_ext_ack, out_core_stall, out_mem_write_en, out_mem_wr_word); end
    tick();
    set_core(0, 0, 12'h0, 16'h0);
    #2;
    checks++; if (mem[12'h040] !== 16'hAAAA) begin failures++; $display("FAIL both_store_mem_core got=%0h exp=aaaa", mem[12'h040]); end
    checks++; if (out_ext_ack !== 1'b1 || out_mem_wr_word !== 16'h5555 || out_mem_addr !== 12'h040) begin failures++; $display("FAIL both_store_ext got=%0h/%0h/%0h exp=1/5555/40", out_ext_ack, out_mem_wr_word, out_mem_addr); end
    tick();
    set_ext(0, 0, 12'h0, 16'h0);
    #2;
    checks++; if (mem[12'h040] !== 16'h5555 || out_ext_rd_valid !== 1'b0) begin failures++; $display("FAIL both_store_mem_ext got=%0h/%0h exp=5555/0", mem[12'h040], out_ext_rd_valid); end
    tick();
  endtask

  initial begin
    test_reset();
    test_core_only();
    test_ext_only();
    test_contention();
    test_drop_on_force();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port data memory (DMEM) between the pipeline's memory stage (core port) and an external requester (loader/debug/DMA port). The core normally has priority and is stalled only when it loses arbitration. A starvation counter forces one external grant after a bounded wait. The block sits between the memory stage's DMEM outputs and the DMEM macro, and drives the pipeline stall.

## Interface
- DMEM_ADDR_WIDTH, 12, DMEM address width
- DMEM_WORD_WIDTH, 16, DMEM word width
- STARVE_LIMIT, 4, consecutive losing cycles before the external port is forced (range 1..15)
- CNT_WIDTH, 4, width of the starvation counter

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- in_core_load  in  1  core read request this cycle
- in_core_store  in  1  core write request this cycle
- in_core_addr  in  DMEM_ADDR_WIDTH  core address (read or write)
- in_core_wr_word  in  DMEM_WORD_WIDTH  core write data
- out_core_stall  out  1  core request present but not granted this cycle
- in_ext_req  in  1  external request, held until ack
- in_ext_we  in  1  1 = write, 0 = read
- in_ext_addr  in  DMEM_ADDR_WIDTH  external address
- in_ext_wr_word  in  DMEM_WORD_WIDTH  external write data
- out_ext_ack  out  1  external request granted this cycle
- out_ext_rd_valid  out  1  external read data valid (cycle after granted read)
- out_ext_rd_word  out  DMEM_WORD_WIDTH  external read data
- in_mem_rd_word  in  DMEM_WORD_WIDTH  DMEM read data, valid the cycle after the address
- out_mem_addr  out  DMEM_ADDR_WIDTH  DMEM address
- out_mem_wr_word  out  DMEM_WORD_WIDTH  DMEM write data
- out_mem_write_en  out  1  DMEM write enable

## Operation
- core_req = in_core_load | in_core_store. Load and store asserted together is illegal; store takes effect.
- FSM has two states.
  - ST_CORE (reset state): core wins when core_req. Ext is granted only when !core_req.
  - ST_FORCE: ext wins when in_ext_req, and the core is stalled.
- Grant decision is combinational from the state and the current requests.
- Exactly one grant or none per cycle.
- Starvation counter wait_cnt:
  - Increments when in_ext_req && !ext_grant.
  - Cleared on ext grant, or when in_ext_req = 0.
  - Saturates at STARVE_LIMIT.
- Transitions:
  - ST_CORE -> ST_FORCE when in_ext_req && !ext_grant && wait_cnt == STARVE_LIMIT-1.
  - ST_FORCE -> ST_CORE after one ext grant, or when in_ext_req = 0. wait_cnt is cleared in either case.
- DMEM port muxing:
  - Core grant: out_mem_addr = in_core_addr, out_mem_wr_word = in_core_wr_word, out_mem_write_en = in_core_store.
  - Ext grant: out_mem_addr = in_ext_addr, out_mem_wr_word = in_ext_wr_word, out_mem_write_en = in_ext_we.
  - No grant: address 0, data 0, write_en 0.
- out_core_stall = core_req && !core_grant.
- out_ext_ack = ext_grant.
- rd_pending_ff <= ext_grant && !in_ext_we.
  - out_ext_rd_valid = rd_pending_ff.
  - out_ext_rd_word = rd_pending_ff ? in_mem_rd_word : 0.
- Core read data is not routed here. The memory stage takes in_mem_rd_word directly one cycle after its un-stalled load.

## Timing
- Reset values:
  - State ST_CORE, wait_cnt 0, rd_pending_ff 0.
  - out_ext_rd_valid 0, out_ext_rd_word 0.
  - Combinational outputs follow the inputs. Under reset, ext grant is possible only when the core is idle.
- Grant and DMEM drive: 0 cycles (combinational).
- Ext read data: valid exactly 1 cycle after out_ext_ack.
- Ext write: committed in the ack cycle.
- Ext handshake: the requester holds req/we/addr/data stable until it sees ack, and may drop req or issue a new request the cycle after ack.
- Worst-case ext wait with the core continuously requesting: STARVE_LIMIT cycles, then granted in cycle STARVE_LIMIT+1.
- Core stall: at most 1 cycle per forced grant. The stalled core request is re-presented and granted the next cycle unless ext is still forced.
- Reset asserted mid-operation: the pending ext read is dropped (rd_valid 0 and never reissued), state returns to ST_CORE, and the counter clears asynchronously.

## Test plan
- Core only: in_core_store, addr 0x010, data 0xBEEF. Then load 0x010 -> write_en 1 in cycle 0, rd_word 0xBEEF next cycle, stall never asserted.
- Ext only, core idle: ext write 0x020 = 0x1234, then ext read 0x020 -> ack same cycle each time, rd_valid 1 with 0x1234 one cycle after the read ack, wait_cnt stays 0.
- Contention, STARVE_LIMIT=4: core loads every cycle, ext read held from cycle 0 -> ack 0 for cycles 0-3, ack 1 and out_core_stall 1 in cycle 4, core granted again in cycle 5, rd_valid in cycle 5.
- Ext drops req in the cycle it would be forced (state ST_FORCE) -> no ack, stall 0, state returns to ST_CORE, wait_cnt 0.
- Reset asserted the cycle after an ext read ack -> rd_valid 0 immediately, state ST_CORE. After release, core and ext behave as from power-up.
- Simultaneous store by both ports with core idle the previous cycle, state ST_CORE -> core store wins, ext waits, DMEM holds the core data; the ext store lands later on ack.
